// File: rtl/decode_stage.sv
// decode_stage: instruction decode stage of a 5-stage MIPS pipeline.
// Holds the 32x32 register file (written from writeback), the main and
// ALU-control decoders, the sign extender and the ID/EX pipeline register.
// Optional build macro REGFILE_BYPASS_EN: when defined, a register being
// written by writeback in the same cycle is forwarded to the read ports.
module decode_stage #(
    parameter int          NREGS    = 32,
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flushE,
    input  logic [31:0] instrD,
    input  logic [31:0] pcD,
    input  logic [31:0] pcplus4D,
    input  logic        regwriteW,
    input  logic [4:0]  writeregW,
    input  logic [31:0] resultW,
    output logic        regwriteE,
    output logic        memtoregE,
    output logic        memwriteE,
    output logic        branchE,
    output logic        alusrcE,
    output logic        regdstE,
    output logic [2:0]  alucontrolE,
    output logic [31:0] rd1E,
    output logic [31:0] rd2E,
    output logic [31:0] immE,
    output logic [4:0]  rsE,
    output logic [4:0]  rtE,
    output logic [4:0]  rdE,
    output logic [31:0] pcE,
    output logic [31:0] pcplus4E
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    logic [31:0] regs [NREGS];

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] rd1;
    logic [31:0] rd2;

    logic        regwrite;
    logic        memtoreg;
    logic        memwrite;
    logic        branch;
    logic        alusrc;
    logic        regdst;
    logic [2:0]  alucontrol;

    // shamt is not used by any supported instruction
    logic        unused_shamt;

    assign opcode       = instrD[31:26];
    assign rs           = instrD[25:21];
    assign rt           = instrD[20:16];
    assign rd           = instrD[15:11];
    assign funct        = instrD[5:0];
    assign imm          = {{16{instrD[15]}}, instrD[15:0]};
    assign unused_shamt = ^instrD[10:6];

    // Register file: cleared on reset, written from writeback; $0 never written
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (regwriteW && (writeregW != 5'd0)) begin
            regs[writeregW] <= resultW;
        end
    end

    // Combinational read ports; $0 reads as zero, optional writeback forwarding
    always_comb begin
        rd1 = (rs == 5'd0) ? 32'd0 : regs[rs];
        rd2 = (rt == 5'd0) ? 32'd0 : regs[rt];
`ifdef REGFILE_BYPASS_EN
        if (regwriteW && (writeregW != 5'd0) && (writeregW == rs)) begin
            rd1 = resultW;
        end
        if (regwriteW && (writeregW != 5'd0) && (writeregW == rt)) begin
            rd2 = resultW;
        end
`endif
    end

    // Main and ALU-control decode; unsupported opcodes or functs become a NOP
    always_comb begin
        regwrite   = 1'b0;
        memtoreg   = 1'b0;
        memwrite   = 1'b0;
        branch     = 1'b0;
        alusrc     = 1'b0;
        regdst     = 1'b0;
        alucontrol = 3'b000;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD: begin regwrite = 1'b1; regdst = 1'b1; alucontrol = 3'b010; end
                    FN_SUB: begin regwrite = 1'b1; regdst = 1'b1; alucontrol = 3'b110; end
                    FN_AND: begin regwrite = 1'b1; regdst = 1'b1; alucontrol = 3'b000; end
                    FN_OR:  begin regwrite = 1'b1; regdst = 1'b1; alucontrol = 3'b001; end
                    FN_SLT: begin regwrite = 1'b1; regdst = 1'b1; alucontrol = 3'b111; end
                    default: begin end
                endcase
            end
            OP_LW: begin
                regwrite   = 1'b1;
                alusrc     = 1'b1;
                memtoreg   = 1'b1;
                alucontrol = 3'b010;
            end
            OP_SW: begin
                memwrite   = 1'b1;
                alusrc     = 1'b1;
                alucontrol = 3'b010;
            end
            OP_BEQ: begin
                branch     = 1'b1;
                alucontrol = 3'b110;
            end
            OP_ADDI: begin
                regwrite   = 1'b1;
                alusrc     = 1'b1;
                alucontrol = 3'b010;
            end
            default: begin end
        endcase
    end

    // ID/EX pipeline register: reset and flush both load a bubble
    always_ff @(posedge clk) begin
        if (rst || flushE) begin
            regwriteE   <= 1'b0;
            memtoregE   <= 1'b0;
            memwriteE   <= 1'b0;
            branchE     <= 1'b0;
            alusrcE     <= 1'b0;
            regdstE     <= 1'b0;
            alucontrolE <= 3'b000;
            rd1E        <= 32'd0;
            rd2E        <= 32'd0;
            immE        <= 32'd0;
            rsE         <= 5'd0;
            rtE         <= 5'd0;
            rdE         <= 5'd0;
            pcE         <= RESET_PC;
            pcplus4E    <= RESET_PC;
        end else begin
            regwriteE   <= regwrite;
            memtoregE   <= memtoreg;
            memwriteE   <= memwrite;
            branchE     <= branch;
            alusrcE     <= alusrc;
            regdstE     <= regdst;
            alucontrolE <= alucontrol;
            rd1E        <= rd1;
            rd2E        <= rd2;
            immE        <= imm;
            rsE         <= rs;
            rtE         <= rt;
            rdE         <= rd;
            pcE         <= pcD;
            pcplus4E    <= pcplus4D;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed self-checking bench for decode_stage.
// Honours REGFILE_BYPASS_EN for the same-cycle write/read expectation.
module tb_decode_stage;

    logic        clk;
    logic        rst;
    logic        flushE;
    logic [31:0] instrD;
    logic [31:0] pcD;
    logic [31:0] pcplus4D;
    logic        regwriteW;
    logic [4:0]  writeregW;
    logic [31:0] resultW;
    logic        regwriteE;
    logic        memtoregE;
    logic        memwriteE;
    logic        branchE;
    logic        alusrcE;
    logic        regdstE;
    logic [2:0]  alucontrolE;
    logic [31:0] rd1E;
    logic [31:0] rd2E;
    logic [31:0] immE;
    logic [4:0]  rsE;
    logic [4:0]  rtE;
    logic [4:0]  rdE;
    logic [31:0] pcE;
    logic [31:0] pcplus4E;

    // packed view: regwrite, memtoreg, memwrite, branch, alusrc, regdst, alu[2:0]
    logic [8:0]  ctrl;
    assign ctrl = {regwriteE, memtoregE, memwriteE, branchE, alusrcE, regdstE, alucontrolE};

    int checks = 0;
    int errors = 0;

    decode_stage #(.NREGS(32), .RESET_PC(32'h00000000)) dut (
        .clk(clk), .rst(rst), .flushE(flushE),
        .instrD(instrD), .pcD(pcD), .pcplus4D(pcplus4D),
        .regwriteW(regwriteW), .writeregW(writeregW), .resultW(resultW),
        .regwriteE(regwriteE), .memtoregE(memtoregE), .memwriteE(memwriteE),
        .branchE(branchE), .alusrcE(alusrcE), .regdstE(regdstE),
        .alucontrolE(alucontrolE), .rd1E(rd1E), .rd2E(rd2E), .immE(immE),
        .rsE(rsE), .rtE(rtE), .rdE(rdE), .pcE(pcE), .pcplus4E(pcplus4E)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // advance one rising edge and settle just past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flushE = 1'b0; instrD = 32'h0; pcD = 32'h0; pcplus4D = 32'h0;
        regwriteW = 1'b0; writeregW = 5'd0; resultW = 32'h0;

        // reset for two cycles
        tick();
        tick();
        check("reset_ctrl", {23'd0, ctrl}, 32'd0);
        check("reset_rd1", rd1E, 32'd0);
        check("reset_imm", immE, 32'd0);
        check("reset_pc", pcE, 32'd0);
        check("reset_pcplus4", pcplus4E, 32'd0);
        check("reset_rsrtrd", {17'd0, rsE, rtE, rdE}, 32'd0);

        // read reg9 after reset -> zero
        rst = 1'b0;
        instrD = 32'h01295020;
        tick();
        check("post_reset_rd1", rd1E, 32'd0);
        check("post_reset_rd2", rd2E, 32'd0);

        // addi $t0,$zero,-5
        instrD = 32'h2008FFFB; pcD = 32'h10; pcplus4D = 32'h14;
        tick();
        check("addi_ctrl", {23'd0, ctrl}, {23'd0, 9'b1_0_0_0_1_0_010});
        check("addi_imm", immE, 32'hFFFFFFFB);
        check("addi_rt", {27'd0, rtE}, 32'd8);
        check("addi_rs", {27'd0, rsE}, 32'd0);
        check("addi_pc", pcE, 32'h10);
        check("addi_pcplus4", pcplus4E, 32'h14);

        // write reg9 while decoding a bubble
        instrD = 32'h0; pcD = 32'h0; pcplus4D = 32'h0;
        regwriteW = 1'b1; writeregW = 5'd9; resultW = 32'hDEADBEEF;
        tick();
        check("nop_ctrl", {23'd0, ctrl}, 32'd0);

        // add $10,$9,$9 reads the written value
        regwriteW = 1'b0;
        instrD = 32'h01295020;
        tick();
        check("add_rd1", rd1E, 32'hDEADBEEF);
        check("add_rd2", rd2E, 32'hDEADBEEF);
        check("add_ctrl", {23'd0, ctrl}, {23'd0, 9'b1_0_0_0_0_1_010});
        check("add_rd", {27'd0, rdE}, 32'd10);
        check("add_rs", {27'd0, rsE}, 32'd9);

        // same-cycle write and read of reg9
        regwriteW = 1'b1; writeregW = 5'd9; resultW = 32'h12345678;
        tick();
`ifdef REGFILE_BYPASS_EN
        check("samecycle_rd1", rd1E, 32'h12345678);
        check("samecycle_rd2", rd2E, 32'h12345678);
`else
        check("samecycle_rd1", rd1E, 32'hDEADBEEF);
        check("samecycle_rd2", rd2E, 32'hDEADBEEF);
`endif
        regwriteW = 1'b0;
        tick();
        check("after_write_rd1", rd1E, 32'h12345678);

        // flush while decoding lw, with a writeback to reg3 in the same cycle
        flushE = 1'b1; instrD = 32'h8C020004; pcD = 32'h40; pcplus4D = 32'h44;
        regwriteW = 1'b1; writeregW = 5'd3; resultW = 32'd7;
        tick();
        check("flush_ctrl", {23'd0, ctrl}, 32'd0);
        check("flush_rd1", rd1E, 32'd0);
        check("flush_imm", immE, 32'd0);
        check("flush_rt", {27'd0, rtE}, 32'd0);
        check("flush_pc", pcE, 32'd0);
        check("flush_pcplus4", pcplus4E, 32'd0);

        // add $4,$3,$3 sees reg3 written during the flush
        flushE = 1'b0; regwriteW = 1'b0;
        instrD = 32'h00632020;
        tick();
        check("reg3_rd1", rd1E, 32'd7);
        check("reg3_rd2", rd2E, 32'd7);

        // lw without flush
        instrD = 32'h8C020004;
        tick();
        check("lw_ctrl", {23'd0, ctrl}, {23'd0, 9'b1_1_0_0_1_0_010});
        check("lw_imm", immE, 32'd4);
        check("lw_rt", {27'd0, rtE}, 32'd2);

        // write to $0 is ignored, with same-cycle read of $0
        instrD = 32'h00002020;
        regwriteW = 1'b1; writeregW = 5'd0; resultW = 32'hFFFFFFFF;
        tick();
        check("zero_samecycle_rd1", rd1E, 32'd0);
        regwriteW = 1'b0;
        tick();
        check("zero_rd1", rd1E, 32'd0);
        check("zero_rd2", rd2E, 32'd0);

        // unknown opcode 0x3F
        instrD = 32'hFC000000;
        tick();
        check("unknown_op_ctrl", {23'd0, ctrl}, 32'd0);

        // sw with negative offset
        instrD = 32'hAC0A8000;
        tick();
        check("sw_ctrl", {23'd0, ctrl}, {23'd0, 9'b0_0_1_0_1_0_010});
        check("sw_imm", immE, 32'hFFFF8000);

        // beq
        instrD = 32'h10000004;
        tick();
        check("beq_ctrl", {23'd0, ctrl}, {23'd0, 9'b0_0_0_1_0_0_110});

        // R-type funct variants
        instrD = 32'h01295022;
        tick();
        check("sub_ctrl", {23'd0, ctrl}, {23'd0, 9'b1_0_0_0_0_1_110});
        instrD = 32'h01295024;
        tick();
        check("and_ctrl", {23'd0, ctrl}, {23'd0, 9'b1_0_0_0_0_1_000});
        instrD = 32'h01295025;
        tick();
        check("or_ctrl", {23'd0, ctrl}, {23'd0, 9'b1_0_0_0_0_1_001});
        instrD = 32'h0129502A;
        tick();
        check("slt_ctrl", {23'd0, ctrl}, {23'd0, 9'b1_0_0_0_0_1_111});
        instrD = 32'h01295021;
        tick();
        check("unknown_funct_ctrl", {23'd0, ctrl}, 32'd0);

        // reset has priority over flush and writeback
        rst = 1'b1; flushE = 1'b1;
        regwriteW = 1'b1; writeregW = 5'd9; resultW = 32'hCAFEF00D;
        instrD = 32'h01295020;
        tick();
        check("rst_prio_ctrl", {23'd0, ctrl}, 32'd0);
        rst = 1'b0; flushE = 1'b0; regwriteW = 1'b0;
        tick();
        check("rst_clears_reg9", rd1E, 32'd0);
        check("rst_prio_add_ctrl", {23'd0, ctrl}, {23'd0, 9'b1_0_0_0_0_1_010});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
